// File: rtl/sort_mem_loader.sv
// sort_mem_loader: streams one frame into the sort memory, then kicks off the sort and waits for it to finish
//   clk, rst (async, active-high)
//   s_valid/s_data/s_last/s_ready : input word stream
//   mem_we/mem_addr/mem_wdata     : registered memory write port
//   sort_start/sort_len/sort_done : handshake with the sort engine
//   busy, trunc                   : status (trunc = frame cut at DEPTH words)
module sort_mem_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              sort_start,
  output logic [ADDR_W:0]   sort_len,
  input  logic              sort_done,
  output logic              busy,
  output logic              trunc
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_START, S_WAIT} state_t;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);
  state_t              state_q, state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     sort_len_q, sort_len_d;
  logic                trunc_q, trunc_d;
  logic                accept, full, done;
  assign s_ready    = state_q == S_IDLE || state_q == S_LOAD;
  assign sort_start = state_q == S_START;
  assign busy       = state_q != S_IDLE;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign sort_len   = sort_len_q;
  assign trunc      = trunc_q;
  assign accept     = s_valid & s_ready;
  assign full       = wr_ptr_q == LAST_PTR;
  assign done       = state_q == S_WAIT && sort_done;
  always_comb begin
    mem_we_d    = accept;
    mem_addr_d  = accept ? wr_ptr_q[ADDR_W-1:0] : mem_addr_q;
    mem_wdata_d = accept ? s_data : mem_wdata_q;
    wr_ptr_d    = accept ? wr_ptr_q + (ADDR_W+1)'(1) : done ? '0 : wr_ptr_q;
    trunc_d     = accept ? (state_q == S_LOAD && trunc_q) || (full && !s_last) : trunc_q;
    sort_len_d  = state_q == S_FLUSH ? wr_ptr_q : sort_len_q;
    state_d     = accept ? ((s_last || full) ? S_FLUSH : S_LOAD) :
                  state_q == S_FLUSH ? S_START :
                  state_q == S_START ? S_WAIT :
                  done ? S_IDLE : state_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sort_len_q  <= '0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      sort_len_q  <= sort_len_d;
      trunc_q     <= trunc_d;
    end
  end
endmodule

// File: tb/tb_sort_mem_loader.sv
// tb_sort_mem_loader: directed self-checking bench for sort_mem_loader
module tb_sort_mem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        sort_start;
  logic [8:0]  sort_len;
  logic        sort_done = 1'b0;
  logic        busy;
  logic        trunc;
  int          tests = 0;
  int          fails = 0;
  sort_mem_loader dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .sort_start(sort_start), .sort_len(sort_len), .sort_done(sort_done),
    .busy(busy), .trunc(trunc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_reset();
    chk("rst_ready", s_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_start", sort_start, 0);
    chk("rst_len", sort_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", trunc, 0);
  endtask
  // present one word for one cycle (called at a negedge), then check its registered write
  task automatic word(input logic [15:0] d, input logic l, input logic [7:0] a);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    chk("ready", s_ready, 1);
    @(negedge clk);
    chk("we", mem_we, 1);
    chk("addr", mem_addr, a);
    chk("wdata", mem_wdata, d);
  endtask
  // called in the FLUSH cycle: checks FLUSH, START and WAIT, then optionally releases with sort_done
  task automatic tail(input logic [8:0] len, input logic tr, input logic release_it);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("flush_ready", s_ready, 0);
    chk("flush_start", sort_start, 0);
    @(negedge clk);
    chk("we_after_flush", mem_we, 0);
    chk("start_pulse", sort_start, 1);
    chk("len", sort_len, len);
    chk("trunc", trunc, tr);
    chk("start_ready", s_ready, 0);
    @(negedge clk);
    chk("start_gone", sort_start, 0);
    chk("wait_ready", s_ready, 0);
    chk("wait_busy", busy, 1);
    chk("wait_len", sort_len, len);
    if (release_it) begin
      sort_done = 1'b1;
      @(negedge clk);
      sort_done = 1'b0;
      chk("idle_ready", s_ready, 1);
      chk("idle_busy", busy, 0);
      chk("idle_trunc", trunc, tr);
    end
  endtask
  initial begin
    #2;
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset();
    // four-word frame
    word(16'h0005, 1'b0, 8'd0);
    word(16'h0003, 1'b0, 8'd1);
    word(16'h0009, 1'b0, 8'd2);
    word(16'h0001, 1'b1, 8'd3);
    tail(9'd4, 1'b0, 1'b1);
    // single word frame
    word(16'hBEEF, 1'b1, 8'd0);
    tail(9'd1, 1'b0, 1'b1);
    // full frame without s_last
    for (int i = 0; i < 255; i++) word(16'(i) ^ 16'hA5A5, 1'b0, 8'(i));
    word(16'd255 ^ 16'hA5A5, 1'b0, 8'd255);
    chk("full_trunc_flush", trunc, 1);
    tail(9'd256, 1'b1, 1'b1);
    // gapped frame with data toggling during gaps; first accept clears trunc
    word(16'h1111, 1'b0, 8'd0);
    chk("trunc_cleared", trunc, 0);
    s_valid = 1'b0;
    s_data  = 16'hDEAD;
    s_last  = 1'b1;
    @(negedge clk);
    chk("gap1_we", mem_we, 0);
    chk("gap1_addr", mem_addr, 0);
    chk("gap1_wdata", mem_wdata, 16'h1111);
    s_data = 16'hF00D;
    @(negedge clk);
    chk("gap2_we", mem_we, 0);
    chk("gap2_wdata", mem_wdata, 16'h1111);
    chk("gap2_busy", busy, 1);
    word(16'h2222, 1'b0, 8'd1);
    word(16'h3333, 1'b1, 8'd2);
    tail(9'd3, 1'b0, 1'b1);
    // sort_done during LOAD and in the sort_start cycle is ignored
    word(16'h0042, 1'b0, 8'd0);
    sort_done = 1'b1;
    word(16'h0043, 1'b1, 8'd1);
    sort_done = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("ld_done_flush", s_ready, 0);
    @(negedge clk);
    chk("ld_done_start", sort_start, 1);
    chk("ld_done_len", sort_len, 2);
    sort_done = 1'b1;
    @(negedge clk);
    sort_done = 1'b0;
    chk("start_done_ignored_ready", s_ready, 0);
    chk("start_done_ignored_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("still_wait", busy, 1);
    s_valid = 1'b1;
    s_data  = 16'h7777;
    s_last  = 1'b1;
    @(negedge clk);
    chk("wait_blocks_we", mem_we, 0);
    s_valid = 1'b0;
    sort_done = 1'b1;
    @(negedge clk);
    sort_done = 1'b0;
    chk("release_ready", s_ready, 1);
    chk("release_busy", busy, 0);
    word(16'h00AA, 1'b1, 8'd0);
    tail(9'd1, 1'b0, 1'b1);
    // asynchronous reset mid-frame
    for (int i = 0; i < 10; i++) word(16'h0100 + 16'(i), 1'b0, 8'(i));
    s_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_start_after_rst", sort_start, 0);
    end
    word(16'h0A0A, 1'b0, 8'd0);
    word(16'h0B0B, 1'b1, 8'd1);
    tail(9'd2, 1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sort_mem_loader.md
Name: sort_mem_loader

Overview:
- Write-side front end of the sort engine's 256x16 word memory.
- Accepts a frame of 16-bit words on a valid/ready stream and writes them to consecutive memory addresses starting at 0.
- Once the frame is in memory, pulses sort_start with the frame length, then blocks new input until the sort engine reports sort_done.
- The sort datapath is the reader of this memory; this block is its writer.

Parameters:
- DATA_W, 16, width of stream and memory words
- ADDR_W, 8, memory address width
- DEPTH, 256, maximum words per frame; must equal 2**ADDR_W

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- s_valid  input  1  stream word valid
- s_data  input  DATA_W  stream word
- s_last  input  1  marks final word of the frame; qualified by s_valid
- s_ready  output  1  loader can accept a word this cycle
- mem_we  output  1  memory write enable, registered
- mem_addr  output  ADDR_W  memory write address, registered
- mem_wdata  output  DATA_W  memory write data, registered
- sort_start  output  1  one-cycle pulse: frame loaded, sort may begin
- sort_len  output  ADDR_W+1  word count of the loaded frame, range 1..DEPTH; held stable from the sort_start cycle until sort_done
- sort_done  input  1  sort engine finished; single-cycle pulse or level accepted
- busy  output  1  high in any state other than IDLE
- trunc  output  1  sticky: the last frame was cut at DEPTH words without s_last

Behaviour:
- Reset (asynchronous, any state) forces:
  - State IDLE, wr_ptr=0.
  - s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0.
  - sort_start=0, sort_len=0, busy=0, trunc=0.
  - Reset mid-frame discards the partial frame; no sort_start is issued.
- Accept condition: accept = s_valid & s_ready. s_ready is combinational from state only, never from s_valid.
- States:
  - IDLE:
    - s_ready=1.
    - On the first accept: trunc cleared, word handled as in LOAD, move to LOAD.
    - If that word has s_last=1, go directly to FLUSH.
  - LOAD:
    - s_ready=1.
    - Each accept registers mem_we=1, mem_addr=wr_ptr, mem_wdata=s_data on the next edge (1-cycle write latency), then wr_ptr+1.
    - If the accepted word has s_last=1 → FLUSH.
    - If the accepted word is at wr_ptr=DEPTH-1 without s_last → set trunc=1 → FLUSH.
    - With no accept, mem_we=0 and mem_addr/mem_wdata hold their last values.
  - FLUSH:
    - s_ready=0; one cycle lets the final registered write land.
    - sort_len = wr_ptr (word count, 9 bits, so 256 is representable).
    - → START.
  - START:
    - sort_start=1 for exactly one cycle; s_ready=0.
    - → WAIT.
  - WAIT:
    - s_ready=0.
    - On sort_done=1: wr_ptr=0 → IDLE.
    - sort_done arriving in the same cycle as sort_start is ignored; it is only sampled in WAIT.
- sort_done in IDLE, LOAD or FLUSH is ignored.
- Words are never dropped. s_data may change freely while s_valid=0.
- Latency:
  - A frame of N words presented back-to-back occupies N cycles of acceptance.
  - Last mem_we is 1 cycle after the last accept.
  - sort_start is 2 cycles after the last accept.
  - Earliest next accept is the cycle after sort_done is sampled in WAIT.
- wr_ptr is ADDR_W+1 bits and never exceeds DEPTH; mem_addr is wr_ptr[ADDR_W-1:0].
- trunc stays set through WAIT and IDLE; it clears only on the first accept of the next frame.

Test Plan:
- Frame of 4 words 0x0005, 0x0003, 0x0009, 0x0001 back-to-back, s_last on the 4th → writes to addr 0..3 one cycle after each accept; sort_start pulses 2 cycles after the 4th accept with sort_len=4, trunc=0; s_ready=0 until sort_done.
- Single word 0xBEEF with s_last in IDLE → one write to addr 0; sort_start with sort_len=1.
- 256 words with no s_last → writes to addr 0..255; s_ready drops after the 256th accept; sort_len=256, trunc=1. Next frame's first accept clears trunc.
- Gapped s_valid (on, off, off, on, on with s_last) while s_data toggles during the gaps → exactly 3 writes, addr 0..2, with the accepted data only; sort_len=3.
- sort_done pulsed during LOAD and in the sort_start cycle → ignored, block stays in WAIT. A later sort_done → IDLE, s_ready=1, next frame starts at addr 0.
- rst asserted mid-frame after 10 accepts → all outputs return to reset values immediately; no sort_start. The following 2-word frame writes addr 0..1 with sort_len=2.
